// File: rtl/yangmips_div_pkg.sv
// rtl/yangmips_div_pkg.sv - shared divider definitions: state encoding, handshake levels, data width
package yangmips_defines;

    localparam int DATA_W = 32;

    // Divider FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // Two's-complement negate when neg is set; used both for operand
    // magnitudes and for the final sign fix-up.
    function automatic logic [DATA_W-1:0] cond_negate(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/yangmips_div.sv
// rtl/yangmips_div.sv - multi-cycle signed/unsigned 32-bit restoring divider for the EX stage
//
// Ports:
//   clk           core clock, rising edge
//   rst           synchronous active-low reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU; sampled with start_i
//   opdata1_i     dividend; sampled with start_i
//   opdata2_i     divisor; sampled with start_i
//   start_i       level request, held until ready_o is seen
//   annul_i       cancel the in-flight division
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
module yangmips_div
    import yangmips_defines::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_e              state_q;
    logic [5:0]              cnt_q;
    logic [2*DATA_W:0]       work_q;
    logic [2*DATA_W:0]       work_d;
    logic [DATA_W-1:0]       divisor_q;
    logic                    neg_quot_q;
    logic                    neg_rem_q;

    logic                    op1_neg;
    logic                    op2_neg;
    logic [DATA_W:0]         diff;
    logic [DATA_W-1:0]       quot_fix;
    logic [DATA_W-1:0]       rem_fix;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];

    // work_q[64:32] is the partial remainder with the next dividend bit
    // already shifted in; a borrow out of the 33-bit subtract means the
    // divisor does not fit this step.
    assign diff = work_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};

    always_comb begin
        work_d = '0;
        if (diff[DATA_W]) begin
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
        end else begin
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
        end
    end

    // After 32 steps the quotient sits in the low word and the remainder
    // in bits 64:33.
    assign quot_fix = cond_negate(neg_quot_q, work_q[DATA_W-1:0]);
    assign rem_fix  = cond_negate(neg_rem_q, work_q[2*DATA_W:DATA_W+1]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ready_o    <= DIV_RESULT_NOT_READY;
            result_o   <= '0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    if (start_i == DIV_START && !annul_i) begin
                        neg_quot_q <= op1_neg ^ op2_neg;
                        neg_rem_q  <= op1_neg;
                        divisor_q  <= cond_negate(op2_neg, opdata2_i);
                        work_q     <= {{DATA_W{1'b0}}, cond_negate(op1_neg, opdata1_i), 1'b0};
                        cnt_q      <= '0;
                        state_q    <= (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: begin
                    if (annul_i) begin
                        state_q <= DIV_FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_READY;
                        state_q  <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state_q  <= DIV_FREE;
                        cnt_q    <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end else if (cnt_q != 6'd32) begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 6'd1;
                    end else begin
                        // Fix-up cycle: apply signs and publish.
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= DIV_RESULT_READY;
                        cnt_q    <= '0;
                        state_q  <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state_q  <= DIV_FREE;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end
                end
                default: begin
                    state_q <= DIV_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yangmips_div.sv
// tb/tb_yangmips_div.sv - scoreboard testbench for yangmips_div
module tb_yangmips_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    yangmips_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_q[$];
    int          edge_q[$];

    // Reference: plain 64-bit arithmetic, truncating division.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'h0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every rising ready_o must match the oldest expectation in value and edge index.
    logic ready_prev = 1'b0;
    always @(negedge clk) begin
        if (ready_o && !ready_prev) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ready: got ready_o=1 result=%h at edge %0d, required no result", result_o, cyc);
            end else begin
                logic [63:0] e;
                int          ee;
                e  = exp_q.pop_front();
                ee = edge_q.pop_front();
                if (result_o !== e || cyc != ee) begin
                    fails++;
                    $display("FAIL result: got %h at edge %0d, required %h at edge %0d", result_o, cyc, e, ee);
                end
            end
        end
        if (!ready_o) begin
            tests++;
            if (result_o !== 64'h0) begin
                fails++;
                $display("FAIL idle_result: got %h with ready_o=0, required 0", result_o);
            end
        end
        ready_prev = ready_o;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Issue one division at a negedge, holding annul for 'blocked' edges first.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int blocked);
        bit got;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        if (blocked > 0) begin
            annul_i = 1'b1;
            repeat (blocked) @(negedge clk);
            annul_i = 1'b0;
        end
        exp_q.push_back(exp);
        edge_q.push_back(cyc + 1 + ((b == 32'd0) ? 1 : 33));
        got = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1'b1;
                break;
            end
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL timeout: no ready_o for %h / %h, required within 45 edges", a, b);
            exp_q.delete();
            edge_q.delete();
            start_i = 1'b0;
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            return;
        end
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("end_hold", {63'b0, ready_o}, 64'h1);
        end
        start_i = 1'b0;
        @(negedge clk);
        check("release", {63'b0, ready_o} | result_o, 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic        s;
        logic [31:0] a, b;

        rst = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'h0;
        opdata2_i = 32'h0;
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", {63'b0, ready_o}, 64'h0);
        check("reset_result", result_o, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived results.
        run_op(1'b0, 32'hFFFFFFFF, 32'h2, {32'h1, 32'h7FFFFFFF}, 0);
        run_op(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        run_op(1'b1, 32'h7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 0);
        run_op(1'b0, 32'h1234, 32'h0, 64'h0, 0);
        run_op(1'b1, 32'h80000000, 32'h0, 64'h0, 0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 0);
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 0);

        // Annul at cycle 10 of a division, then 100/7.
        signed_div_i = 1'b0; opdata1_i = 32'h12345678; opdata2_i = 32'h99; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_on", {63'b0, ready_o} | result_o, 64'h0);
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 0);

        // Annul while in BYZERO.
        signed_div_i = 1'b1; opdata1_i = 32'h55; opdata2_i = 32'h0; start_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_byzero", {63'b0, ready_o}, 64'h0);
        repeat (5) @(negedge clk);

        // Annul in FREE must block acceptance even with start_i held.
        run_op(1'b1, 32'hFFFFFF9C, 32'd7, ref_div(1'b1, 32'hFFFFFF9C, 32'd7), 3);

        // Reset at cycle 20 of a division.
        signed_div_i = 1'b0; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'h3; start_i = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check("reset_mid_op", {63'b0, ready_o} | result_o, 64'h0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 0);

        // Randomized operands against the reference model.
        for (int n = 0; n < 25; n++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = s ? 32'hFFFFFFFF : 32'h1;
                3:       b = a;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 9));
            run_op(s, a, b, ref_div(s, a, b), (n % 6 == 0) ? 2 : 0);
        end

        repeat (5) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected results never seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
